// File: rtl/splitter_pkg.sv
// splitter_ctrl shared types: FSM states, pump phase patterns, valve levels.
// Imported by the controller and by its pump phase generator.
package splitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_PUSH_A = 3'd3,
        ST_PUSH_B = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam logic [2:0] PUMP_PH0  = 3'b011;
    localparam logic [2:0] PUMP_PH1  = 3'b101;
    localparam logic [2:0] PUMP_PH2  = 3'b110;
    localparam logic [2:0] PUMP_HOLD = 3'b111;

    localparam logic VALVE_CLOSED = 1'b1;
    localparam logic VALVE_OPEN   = 1'b0;

    function automatic logic [2:0] pump_pattern(input logic [1:0] ph);
        logic [2:0] p;
        p = PUMP_HOLD;
        case (ph)
            2'd0:    p = PUMP_PH0;
            2'd1:    p = PUMP_PH1;
            2'd2:    p = PUMP_PH2;
            default: p = PUMP_HOLD;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pump_phase_gen.sv
// Peristaltic pump sequencer: runs a stroke count of 3-phase strokes,
// then pulses stroke_done_all in the final cycle of the final stroke.
module pump_phase_gen
    import splitter_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PHASE_CYC = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [CNT_W:0] strokes,
    output logic [2:0]     pump,
    output logic           stroke_done_all
);

    localparam int PC_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [PC_W-1:0] CYC_LAST = PC_W'(PHASE_CYC - 1);
    localparam logic [PC_W-1:0] CYC_ONE  = PC_W'(1);
    localparam logic [CNT_W:0]  STK_ONE  = (CNT_W + 1)'(1);

    logic            active_q, active_d;
    logic [PC_W-1:0] cyc_q, cyc_d;
    logic [1:0]      ph_q, ph_d;
    logic [CNT_W:0]  left_q, left_d;
    logic            last_cyc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cyc_q    <= '0;
            ph_q     <= '0;
            left_q   <= '0;
        end else begin
            active_q <= active_d;
            cyc_q    <= cyc_d;
            ph_q     <= ph_d;
            left_q   <= left_d;
        end
    end

    assign last_cyc = (cyc_q == CYC_LAST);
    assign stroke_done_all = active_q && last_cyc
                           && (ph_q == 2'd2) && (left_q == STK_ONE);

    always_comb begin
        active_d = active_q;
        cyc_d    = cyc_q;
        ph_d     = ph_q;
        left_d   = left_q;
        if (start) begin
            // Every pumping state restarts the pattern at phase 0.
            active_d = 1'b1;
            cyc_d    = '0;
            ph_d     = 2'd0;
            left_d   = strokes;
        end else if (active_q) begin
            if (last_cyc) begin
                cyc_d = '0;
                if (ph_q == 2'd2) begin
                    ph_d   = 2'd0;
                    left_d = left_q - STK_ONE;
                    if (left_q == STK_ONE) begin
                        active_d = 1'b0;
                    end
                end else begin
                    ph_d = ph_q + 2'd1;
                end
            end else begin
                cyc_d = cyc_q + CYC_ONE;
            end
        end
    end

    assign pump = active_q ? pump_pattern(ph_q) : PUMP_HOLD;

endmodule

// File: rtl/splitter_ctrl.sv
// Splitter valve sequencer: FILL the pump with a+b strokes, then push
// a and b strokes to their outlets, with an all-closed settle after each.
module splitter_ctrl
    import splitter_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int PHASE_CYC  = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_vol_a,
    input  logic [CNT_W-1:0] req_vol_b,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             done_err,
    output logic [CNT_W-1:0] done_vol_a,
    output logic [CNT_W-1:0] done_vol_b,
    output logic             valve_in,
    output logic             valve_a,
    output logic             valve_b,
    output logic [2:0]       pump,
    output logic             busy
);

    localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [ST_W-1:0] SET_LAST = ST_W'(SETTLE_CYC - 1);
    localparam logic [ST_W-1:0] SET_ONE  = ST_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] vol_a_q, vol_a_d;
    logic [CNT_W-1:0] vol_b_q, vol_b_d;
    logic             err_q, err_d;
    logic             a_pend_q, a_pend_d;
    logic             b_pend_q, b_pend_d;
    logic [ST_W-1:0]  settle_q, settle_d;

    logic             pg_start;
    logic [CNT_W:0]   pg_strokes;
    logic [2:0]       pg_pump;
    logic             pg_done;
    logic             pumping;

    pump_phase_gen #(
        .CNT_W     (CNT_W),
        .PHASE_CYC (PHASE_CYC)
    ) u_pump (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (pg_start),
        .strokes         (pg_strokes),
        .pump            (pg_pump),
        .stroke_done_all (pg_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vol_a_q  <= '0;
            vol_b_q  <= '0;
            err_q    <= 1'b0;
            a_pend_q <= 1'b0;
            b_pend_q <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            vol_a_q  <= vol_a_d;
            vol_b_q  <= vol_b_d;
            err_q    <= err_d;
            a_pend_q <= a_pend_d;
            b_pend_q <= b_pend_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vol_a_d    = vol_a_q;
        vol_b_d    = vol_b_q;
        err_d      = err_q;
        a_pend_d   = a_pend_q;
        b_pend_d   = b_pend_q;
        settle_d   = settle_q;
        pg_start   = 1'b0;
        pg_strokes = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    vol_a_d  = req_vol_a;
                    vol_b_d  = req_vol_b;
                    a_pend_d = |req_vol_a;
                    b_pend_d = |req_vol_b;
                    if (!(|req_vol_a) && !(|req_vol_b)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d      = 1'b0;
                        state_d    = ST_FILL;
                        pg_start   = 1'b1;
                        pg_strokes = {1'b0, req_vol_a} + {1'b0, req_vol_b};
                    end
                end
            end
            ST_FILL, ST_PUSH_A, ST_PUSH_B: begin
                if (pg_done) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SET_LAST) begin
                    // Zero-volume pushes were never marked pending.
                    if (a_pend_q) begin
                        state_d    = ST_PUSH_A;
                        a_pend_d   = 1'b0;
                        pg_start   = 1'b1;
                        pg_strokes = {1'b0, vol_a_q};
                    end else if (b_pend_q) begin
                        state_d    = ST_PUSH_B;
                        b_pend_d   = 1'b0;
                        pg_start   = 1'b1;
                        pg_strokes = {1'b0, vol_b_q};
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    settle_d = settle_q + SET_ONE;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pumping = (state_q == ST_FILL) || (state_q == ST_PUSH_A)
                   || (state_q == ST_PUSH_B);

    assign req_ready  = (state_q == ST_IDLE);
    assign done_valid = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign done_err   = err_q;
    assign done_vol_a = vol_a_q;
    assign done_vol_b = vol_b_q;

    assign valve_in = (state_q == ST_FILL)   ? VALVE_OPEN : VALVE_CLOSED;
    assign valve_a  = (state_q == ST_PUSH_A) ? VALVE_OPEN : VALVE_CLOSED;
    assign valve_b  = (state_q == ST_PUSH_B) ? VALVE_OPEN : VALVE_CLOSED;
    assign pump     = pumping ? pg_pump : PUMP_HOLD;

endmodule

// File: tb/tb_splitter_ctrl.sv
// Directed bench for splitter_ctrl (PHASE_CYC=4, SETTLE_CYC=2).
// Expected cycle counts and valve-open durations are hand-computed.
module tb_splitter_ctrl;

    localparam int PH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_vol_a = '0;
    logic [7:0] req_vol_b = '0;
    logic       done_valid;
    logic       done_ready = 1'b1;
    logic       done_err;
    logic [7:0] done_vol_a;
    logic [7:0] done_vol_b;
    logic       valve_in;
    logic       valve_a;
    logic       valve_b;
    logic [2:0] pump;
    logic       busy;

    int n_run = 0;
    int n_fail = 0;

    splitter_ctrl #(
        .CNT_W      (8),
        .PHASE_CYC  (PH),
        .SETTLE_CYC (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vol_a  (req_vol_a),
        .req_vol_b  (req_vol_b),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_err   (done_err),
        .done_vol_a (done_vol_a),
        .done_vol_b (done_vol_b),
        .valve_in   (valve_in),
        .valve_a    (valve_a),
        .valve_b    (valve_b),
        .pump       (pump),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] pat(input int p);
        logic [2:0] r;
        case (p)
            0:       r = 3'b011;
            1:       r = 3'b101;
            default: r = 3'b110;
        endcase
        return r;
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_vin"}, valve_in, 1);
        chk({tag, "_va"}, valve_a, 1);
        chk({tag, "_vb"}, valve_b, 1);
        chk({tag, "_pump"}, pump, 3'b111);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_dv"}, done_valid, 0);
        chk({tag, "_derr"}, done_err, 0);
        chk({tag, "_eca"}, done_vol_a, 0);
        chk({tag, "_ecb"}, done_vol_b, 0);
    endtask

    // Accept at cycle 0; returns in the cycle done_valid is first seen.
    task automatic run_split(input logic [7:0] va, input logic [7:0] vb,
                             input int e_cyc, input int e_in,
                             input int e_a, input int e_b,
                             input int e_set, input logic e_err);
        int cyc, n_in, n_a, n_b, n_set, bad, multi, pos, cur, prev;
        n_in = 0; n_a = 0; n_b = 0; n_set = 0;
        bad = 0; multi = 0; pos = 0; prev = 0;
        chk("rdy", req_ready, 1);
        req_valid = 1'b1;
        req_vol_a = va;
        req_vol_b = vb;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_vol_a = 8'($urandom);
        req_vol_b = 8'($urandom);
        cyc = 1;
        while (!done_valid && cyc < 3000) begin
            cur = !valve_in ? 1 : !valve_a ? 2 : !valve_b ? 3 : 0;
            if ((!valve_in && !valve_a) || (!valve_in && !valve_b)
                || (!valve_a && !valve_b)) multi++;
            if (cur != 0) begin
                pos = (cur == prev) ? pos + 1 : 0;
                if (pump !== pat((pos / PH) % 3)) bad++;
            end else if (busy) begin
                n_set++;
                if (pump !== 3'b111) bad++;
            end
            if (cur == 1) n_in++;
            if (cur == 2) n_a++;
            if (cur == 3) n_b++;
            prev = cur;
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_cyc", cyc, e_cyc);
        chk("done_valid", done_valid, 1);
        chk("done_err", done_err, e_err);
        chk("echo_a", done_vol_a, va);
        chk("echo_b", done_vol_b, vb);
        chk("fill_cyc", n_in, e_in);
        chk("pusha_cyc", n_a, e_a);
        chk("pushb_cyc", n_b, e_b);
        chk("settle_cyc", n_set, e_set);
        chk("pump_pat", bad, 0);
        chk("one_open", multi, 0);
        chk("done_pump", pump, 3'b111);
        if (done_ready) begin
            @(posedge clk); #1;
            chk("done_1cyc", done_valid, 0);
            chk("idle_rdy", req_ready, 1);
        end
    endtask

    initial begin
        int k, seen;
        #1;
        chk_reset_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rdy", req_ready, 1);

        run_split(8'd1, 8'd2, 79, 36, 12, 24, 6, 1'b0);
        run_split(8'd0, 8'd3, 77, 36, 0, 36, 4, 1'b0);
        run_split(8'd0, 8'd0, 1, 0, 0, 0, 0, 1'b1);

        // Token held in DONE while a new request waits.
        done_ready = 1'b0;
        run_split(8'd1, 8'd1, 55, 24, 12, 12, 6, 1'b0);
        req_valid = 1'b1;
        req_vol_a = 8'd0;
        req_vol_b = 8'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_dv", done_valid, 1);
            chk("hold_rdy", req_ready, 0);
            chk("hold_ea", done_vol_a, 1);
            chk("hold_err", done_err, 0);
        end
        done_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_dv", done_valid, 0);
        chk("hs_rdy", req_ready, 1);
        @(posedge clk); #1;
        chk("pend_dv", done_valid, 1);
        chk("pend_err", done_err, 1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pend_idle", busy, 0);

        // Reset in the middle of PUSH_A.
        req_valid = 1'b1;
        req_vol_a = 8'd2;
        req_vol_b = 8'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (valve_a && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_pusha", valve_a, 0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done_valid) seen++;
        end
        chk("no_token", seen, 0);
        chk("post_rst_busy", busy, 0);

        run_split(8'd1, 8'd1, 55, 24, 12, 12, 6, 1'b0);
        run_split(8'd2, 8'd0, 53, 24, 24, 0, 4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
